// File: rtl/net_discard_stats_pkg.sv
// Shared definitions for net_discard_stats: MI address map, CMD bits and command FSM states.
package net_discard_stats_pkg;

  localparam int unsigned ADDR_CMD       = 32'h00;
  localparam int unsigned ADDR_STATUS    = 32'h04;
  localparam int unsigned ADDR_CH_BASE   = 32'h10;
  localparam int unsigned ADDR_CH_STRIDE = 32'h10;

  localparam int unsigned OFF_TOTAL_LO = 32'h0;
  localparam int unsigned OFF_TOTAL_HI = 32'h4;
  localparam int unsigned OFF_DISC_LO  = 32'h8;
  localparam int unsigned OFF_DISC_HI  = 32'hC;

  localparam int unsigned CMD_SNAP_BIT = 0;
  localparam int unsigned CMD_CLR_BIT  = 1;

  localparam int unsigned STATUS_SNAP_VALID_BIT = 0;
  localparam int unsigned STATUS_OVF_ANY_BIT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNAP     = 2'd1,
    ST_SNAP_CLR = 2'd2,
    ST_CLR      = 2'd3
  } cmd_state_e;

  // Number of low address bits that take part in decoding; higher bits alias.
  function automatic int unsigned dec_width(input int unsigned channels);
    return $clog2((channels + 1) * ADDR_CH_STRIDE);
  endfunction

endpackage

// File: rtl/net_discard_stats_if.sv
// MI register bus between a master (CPU side) and net_discard_stats.
interface net_discard_stats_if #(
  parameter int MI_ADDR_WIDTH = 32
);
  logic [31:0]              MI_DWR;
  logic [MI_ADDR_WIDTH-1:0] MI_ADDR;
  logic                     MI_RD;
  logic                     MI_WR;
  logic [3:0]               MI_BE;
  logic [31:0]              MI_DRD;
  logic                     MI_ARDY;
  logic                     MI_DRDY;

  modport master (
    output MI_DWR, MI_ADDR, MI_RD, MI_WR, MI_BE,
    input  MI_DRD, MI_ARDY, MI_DRDY
  );

  modport slave (
    input  MI_DWR, MI_ADDR, MI_RD, MI_WR, MI_BE,
    output MI_DRD, MI_ARDY, MI_DRDY
  );
endinterface

// File: rtl/net_discard_stats_cnt.sv
// One event counter: popcount of a region vector, add, wrap or saturate, sticky overflow, shadow copy.
// Saturation instead of wrap is selected with macro NET_DISCARD_STATS_SATURATE_EN.
module net_discard_stats_cnt #(
  parameter int REGIONS   = 4,
  parameter int CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REGIONS-1:0]   inc_vec,
  input  logic                 snap,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 ovf
);

  localparam int SUM_W = CNT_WIDTH + 4;

  logic [CNT_WIDTH-1:0] live_q, live_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] base;
  logic [SUM_W-1:0]     sum;
  logic                 carry;

  function automatic logic [3:0] popcount(input logic [REGIONS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < REGIONS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] limit(input logic [SUM_W-1:0] s);
`ifdef NET_DISCARD_STATS_SATURATE_EN
    return (|s[SUM_W-1:CNT_WIDTH]) ? '1 : s[CNT_WIDTH-1:0];
`else
    return s[CNT_WIDTH-1:0];
`endif
  endfunction

  // A clear restarts from zero but still takes this cycle's events.
  always_comb begin
    base     = clr ? '0 : live_q;
    sum      = SUM_W'(base) + SUM_W'(popcount(inc_vec));
    carry    = |sum[SUM_W-1:CNT_WIDTH];
    live_d   = limit(sum);
    ovf_d    = (clr ? 1'b0 : ovf_q) | carry;
    shadow_d = snap ? live_q : shadow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q   <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign shadow = shadow_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/net_discard_stats.sv
// Per-channel RX frame and discard counters with snapshot/clear commands over an MI register bus.
// Build option: NET_DISCARD_STATS_SATURATE_EN makes counters saturate instead of wrap.
module net_discard_stats
  import net_discard_stats_pkg::*;
#(
  parameter int ETH_CHANNELS  = 4,
  parameter int REGIONS       = 4,
  parameter int CNT_WIDTH     = 48,
  parameter int MI_DATA_WIDTH = 32,
  parameter int MI_ADDR_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [ETH_CHANNELS*REGIONS-1:0] RX_STAT_VLD,
  input  logic [ETH_CHANNELS*REGIONS-1:0] RX_STAT_DISCARD,
  net_discard_stats_if.slave              mi
);

  localparam int DEC_W = int'(dec_width(ETH_CHANNELS));

  logic [31:0]               word;
  logic                      cmd_wr, snap, clr;
  logic [CNT_WIDTH-1:0]      tot_sh  [ETH_CHANNELS];
  logic [CNT_WIDTH-1:0]      disc_sh [ETH_CHANNELS];
  logic [2*ETH_CHANNELS-1:0] ovf_vec;
  logic [31:0]               rdata;

  cmd_state_e  state_q, state_d;
  logic        snap_valid_q, snap_valid_d;
  logic        drdy_q, drdy_d;
  logic [31:0] drd_q, drd_d;

  assign word   = 32'({mi.MI_ADDR[DEC_W-1:2], 2'b00});
  assign cmd_wr = mi.MI_WR && (word == ADDR_CMD) && mi.MI_BE[0];
  assign snap   = cmd_wr & mi.MI_DWR[CMD_SNAP_BIT];
  assign clr    = cmd_wr & mi.MI_DWR[CMD_CLR_BIT];

  assign mi.MI_ARDY = (mi.MI_RD | mi.MI_WR) & ~RESET;

  for (genvar c = 0; c < ETH_CHANNELS; c++) begin : g_ch
    net_discard_stats_cnt #(.REGIONS(REGIONS), .CNT_WIDTH(CNT_WIDTH)) u_total (
      .clk     (CLK),
      .rst     (RESET),
      .inc_vec (RX_STAT_VLD[c*REGIONS +: REGIONS]),
      .snap    (snap),
      .clr     (clr),
      .shadow  (tot_sh[c]),
      .ovf     (ovf_vec[2*c])
    );
    net_discard_stats_cnt #(.REGIONS(REGIONS), .CNT_WIDTH(CNT_WIDTH)) u_disc (
      .clk     (CLK),
      .rst     (RESET),
      .inc_vec (RX_STAT_VLD[c*REGIONS +: REGIONS] & RX_STAT_DISCARD[c*REGIONS +: REGIONS]),
      .snap    (snap),
      .clr     (clr),
      .shadow  (disc_sh[c]),
      .ovf     (ovf_vec[2*c+1])
    );
  end

  // Command FSM: the state records which command the last accepted CMD write carried.
  always_comb begin
    state_d      = ST_IDLE;
    snap_valid_d = snap_valid_q;
    if (snap && clr) state_d = ST_SNAP_CLR;
    else if (snap)   state_d = ST_SNAP;
    else if (clr)    state_d = ST_CLR;
    if (state_d == ST_SNAP || state_d == ST_SNAP_CLR) snap_valid_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Read mux sees shadows as they were before this edge, so a coincident snapshot is not visible yet.
  always_comb begin
    logic [63:0] t64, d64;
    logic [31:0] base, sub;
    rdata = '0;
    t64   = '0;
    d64   = '0;
    base  = '0;
    sub   = '0;
    if (word == ADDR_STATUS) begin
      rdata[STATUS_SNAP_VALID_BIT] = snap_valid_q;
      rdata[STATUS_OVF_ANY_BIT]    = |ovf_vec;
    end
    for (int c = 0; c < ETH_CHANNELS; c++) begin
      base = 32'(ADDR_CH_BASE + 32'(c) * ADDR_CH_STRIDE);
      sub  = word - base;
      if (word >= base && sub < ADDR_CH_STRIDE) begin
        t64 = 64'(tot_sh[c]);
        d64 = 64'(disc_sh[c]);
        case (sub)
          OFF_TOTAL_LO: rdata = t64[31:0];
          OFF_TOTAL_HI: rdata = t64[63:32];
          OFF_DISC_LO:  rdata = d64[31:0];
          OFF_DISC_HI:  rdata = d64[63:32];
          default:      rdata = '0;
        endcase
      end
    end
    drdy_d = mi.MI_RD;
    drd_d  = mi.MI_RD ? rdata : '0;
  end

  // Read response stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drdy_q <= 1'b0;
      drd_q  <= '0;
    end else begin
      drdy_q <= drdy_d;
      drd_q  <= drd_d;
    end
  end

  assign mi.MI_DRDY = drdy_q;
  assign mi.MI_DRD  = drd_q;

  logic unused_bits;
  assign unused_bits = ^{mi.MI_DWR[31:2], mi.MI_BE[3:1], mi.MI_ADDR, state_q};

endmodule

// File: tb/tb_net_discard_stats.sv
// Directed bench for net_discard_stats: vector table for counting, hand sequences for command corners.
module tb_net_discard_stats;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] vld, disc;
  logic [3:0]  vld4, disc4;
  logic        rd, wr, sel;
  logic [31:0] addr, dwr;
  logic [3:0]  be;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  net_discard_stats_if #(.MI_ADDR_WIDTH(32)) mi0 ();
  net_discard_stats_if #(.MI_ADDR_WIDTH(32)) mi4 ();

  assign mi0.MI_RD   = rd & ~sel;
  assign mi0.MI_WR   = wr & ~sel;
  assign mi0.MI_ADDR = addr;
  assign mi0.MI_DWR  = dwr;
  assign mi0.MI_BE   = be;
  assign mi4.MI_RD   = rd & sel;
  assign mi4.MI_WR   = wr & sel;
  assign mi4.MI_ADDR = addr;
  assign mi4.MI_DWR  = dwr;
  assign mi4.MI_BE   = be;

  net_discard_stats #(
    .ETH_CHANNELS(4), .REGIONS(4), .CNT_WIDTH(48), .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .RX_STAT_VLD     (vld),
    .RX_STAT_DISCARD (disc),
    .mi              (mi0.slave)
  );

  net_discard_stats #(
    .ETH_CHANNELS(1), .REGIONS(4), .CNT_WIDTH(4), .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)
  ) dut4 (
    .CLK             (CLK),
    .RESET           (RESET),
    .RX_STAT_VLD     (vld4),
    .RX_STAT_DISCARD (disc4),
    .mi              (mi4.slave)
  );

  logic        ardy, drdy;
  logic [31:0] drd;
  assign ardy = sel ? mi4.MI_ARDY : mi0.MI_ARDY;
  assign drdy = sel ? mi4.MI_DRDY : mi0.MI_DRDY;
  assign drd  = sel ? mi4.MI_DRD  : mi0.MI_DRD;

  typedef struct {
    int          ch;
    logic [3:0]  v;
    logic [3:0]  d;
    int          cyc;
    logic [63:0] tot;
    logic [63:0] dsc;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic mi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = 1'b1; addr = a; dwr = d; be = b;
    step();
    wr = 1'b0; dwr = '0; be = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk({nm, "_ardy"}, 64'(ardy), 64'd1);
    step();
    rd = 1'b0;
    chk({nm, "_drdy"}, 64'(drdy), 64'd1);
    chk(nm, 64'(drd), 64'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] et, ed;
    logic [31:0] exp4;

    vecs[0] = '{1, 4'b1111, 4'b0101, 10, 64'd40, 64'd20};
    vecs[1] = '{0, 4'b0011, 4'b1111, 5,  64'd10, 64'd10};
    vecs[2] = '{3, 4'b1000, 4'b0000, 7,  64'd7,  64'd0};
    vecs[3] = '{2, 4'b0110, 4'b0010, 3,  64'd6,  64'd3};
    vecs[4] = '{2, 4'b0000, 4'b1111, 4,  64'd0,  64'd0};

    RESET = 1'b1; vld = '0; disc = '0; vld4 = '0; disc4 = '0;
    rd = 1'b1; wr = 1'b0; sel = 1'b0; addr = 32'h4; dwr = '0; be = '0;
    #2;
    chk("rst_ardy", 64'(ardy), 64'd0);
    chk("rst_drdy", 64'(drdy), 64'd0);
    chk("rst_drd",  64'(drd),  64'd0);
    rd = 1'b0;
    step();
    step();
    RESET = 1'b0;
    step();

    // Status before any snapshot, and DRDY lasting exactly one cycle.
    rd_chk("status_init", 32'h4, 32'h0);
    step();
    chk("drdy_one_cycle", 64'(drdy), 64'd0);

    for (int i = 0; i < 5; i++) begin
      mi_write(32'h0, 32'h2, 4'hF);
      vld = '0; disc = '0;
      vld[vecs[i].ch*4 +: 4]  = vecs[i].v;
      disc[vecs[i].ch*4 +: 4] = vecs[i].d;
      repeat (vecs[i].cyc) step();
      vld = '0; disc = '0;
      mi_write(32'h0, 32'h1, 4'hF);
      for (int c = 0; c < 4; c++) begin
        et = (c == vecs[i].ch) ? vecs[i].tot : 64'd0;
        ed = (c == vecs[i].ch) ? vecs[i].dsc : 64'd0;
        rd_chk($sformatf("v%0d_c%0d_tot_lo", i, c), 32'(16 + c*16),      et[31:0]);
        rd_chk($sformatf("v%0d_c%0d_tot_hi", i, c), 32'(16 + c*16 + 4),  et[63:32]);
        rd_chk($sformatf("v%0d_c%0d_dsc_lo", i, c), 32'(16 + c*16 + 8),  ed[31:0]);
        rd_chk($sformatf("v%0d_c%0d_dsc_hi", i, c), 32'(16 + c*16 + 12), ed[63:32]);
      end
      if (i == 0) begin
        rd_chk("status_snap", 32'h4, 32'h1);
        rd_chk("alias_hi_bits", 32'h1000_0020, 32'd40);
        rd_chk("cmd_reads_0", 32'h0, 32'h0);
        rd_chk("unmapped_08", 32'h8, 32'h0);
        rd_chk("unmapped_50", 32'h50, 32'h0);
      end
    end

    // Snapshot and clear together while ch0 is counting.
    mi_write(32'h0, 32'h2, 4'hF);
    vld[3:0] = 4'b0011;
    repeat (3) step();
    mi_write(32'h0, 32'h3, 4'hF);
    vld = '0;
    rd_chk("snapclr_prior", 32'h10, 32'd6);
    mi_write(32'h0, 32'h1, 4'hF);
    rd_chk("snapclr_live", 32'h10, 32'd2);

    // CMD write without byte lane 0 must not snapshot.
    vld[3:0] = 4'b1111;
    repeat (2) step();
    vld = '0;
    mi_write(32'h0, 32'h1, 4'b1110);
    rd_chk("be_masked_tot", 32'h10, 32'd2);
    rd_chk("be_masked_dsc", 32'h18, 32'd0);
    mi_write(32'h0, 32'h1, 4'hF);
    rd_chk("be_full_tot", 32'h10, 32'd10);

    // Read coinciding with a snapshot returns the earlier shadow.
    vld[7:4] = 4'b0001;
    step();
    vld = '0;
    rd = 1'b1; wr = 1'b1; addr = 32'h0; dwr = 32'h1; be = 4'hF;
    step();
    rd = 1'b0; wr = 1'b0;
    chk("coincide_cmd_read", 64'(drd), 64'd0);
    rd_chk("coincide_after", 32'h20, 32'd1);

    // Reset asserted while a read is pending and traffic is running.
    vld = 16'hFFFF; disc = 16'hFFFF;
    repeat (3) step();
    rd = 1'b1; addr = 32'h20;
    #2;
    RESET = 1'b1;
    #1;
    chk("rstmid_ardy", 64'(ardy), 64'd0);
    chk("rstmid_drdy", 64'(drdy), 64'd0);
    chk("rstmid_drd",  64'(drd),  64'd0);
    rd = 1'b0;
    step();
    chk("rstmid_drdy_edge", 64'(drdy), 64'd0);
    vld = '0; disc = '0;
    RESET = 1'b0;
    step();
    chk("rstmid_drdy_after", 64'(drdy), 64'd0);
    rd_chk("rstmid_status", 32'h4, 32'h0);
    for (int c = 0; c < 4; c++) begin
      rd_chk($sformatf("rstmid_c%0d_tot", c), 32'(16 + c*16), 32'h0);
      rd_chk($sformatf("rstmid_c%0d_dsc", c), 32'(16 + c*16 + 8), 32'h0);
    end
    mi_write(32'h0, 32'h1, 4'hF);
    for (int c = 0; c < 4; c++)
      rd_chk($sformatf("rstmid_live_c%0d", c), 32'(16 + c*16), 32'h0);

    // Narrow 4-bit counter overflow.
    sel = 1'b1;
    vld4 = 4'b0001;
    repeat (17) step();
    vld4 = '0;
    mi_write(32'h0, 32'h1, 4'hF);
`ifdef NET_DISCARD_STATS_SATURATE_EN
    exp4 = 32'd15;
`else
    exp4 = 32'd1;
`endif
    rd_chk("w4_total", 32'h10, exp4);
    rd_chk("w4_total_hi", 32'h14, 32'h0);
    rd_chk("w4_status_ovf", 32'h4, 32'h3);
    mi_write(32'h0, 32'h2, 4'hF);
    rd_chk("w4_status_clr", 32'h4, 32'h1);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
